// File: rtl/uart_echo_pkg.sv
// Shared types and constants for the UART echo controller.
package uart_echo_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GUARD    = 2'd1,
    WAIT_RDY = 2'd2
  } state_t;

  localparam logic [7:0] CHR_CR = 8'h0D;
  localparam logic [7:0] CHR_LF = 8'h0A;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with first-word fall-through read data.
module byte_fifo
  import uart_echo_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      wr_en,
  input  logic [7:0]                wr_data,
  input  logic                      rd_en,
  output logic [7:0]                rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  // A read in the same cycle frees the head slot, so a write into a full FIFO is still taken.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      assert (!(rd_en && empty));
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_echo_ctrl.sv
// Echo controller: queues received bytes and replays them to the UART transmitter.
module uart_echo_ctrl
  import uart_echo_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter bit          CRLF_EXPAND = 1'b1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [7:0]                recv_data,
  input  logic                      vald_data,
  input  logic                      ready,
  output logic                      send,
  output logic [7:0]                send_data,
  output logic [cnt_w(DEPTH)-1:0]   fifo_count,
  output logic                      overflow
);

  state_t     state_q;
  state_t     state_d;
  logic       send_d;
  logic [7:0] data_d;
  logic       lf_q;
  logic       lf_d;
  logic       ovf_d;
  logic       pop;
  logic [7:0] head;
  logic       full;
  logic       empty;

  byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (vald_data),
    .wr_data (recv_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      send      <= 1'b0;
      send_data <= '0;
      lf_q      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      send      <= send_d;
      send_data <= data_d;
      lf_q      <= lf_d;
      overflow  <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    send_d  = 1'b0;
    data_d  = send_data;
    lf_d    = lf_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && ready) begin
          pop     = 1'b1;
          data_d  = head;
          send_d  = 1'b1;
          lf_d    = CRLF_EXPAND && (head == CHR_CR);
          state_d = GUARD;
        end
      end
      GUARD: begin
        state_d = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (ready) begin
          if (lf_q) begin
            data_d  = CHR_LF;
            send_d  = 1'b1;
            lf_d    = 1'b0;
            state_d = GUARD;
          end else if (!empty) begin
            pop     = 1'b1;
            data_d  = head;
            send_d  = 1'b1;
            lf_d    = CRLF_EXPAND && (head == CHR_CR);
            state_d = GUARD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ovf_d = overflow || (vald_data && full && !pop);
  end

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Bench for uart_echo_ctrl: queue-based model plus directed scenarios.
module tb_uart_echo_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] recv_data;
  logic       vald_data;
  logic       ready;

  logic       send_a, send_b;
  logic [7:0] sd_a, sd_b;
  logic [2:0] cnt_a;
  logic [4:0] cnt_b;
  logic       ovf_a, ovf_b;

  always #5 CLK = ~CLK;

  uart_echo_ctrl #(
    .DEPTH       (4),
    .CRLF_EXPAND (1'b1)
  ) dut_a (
    .CLK        (CLK),
    .RST        (RST),
    .recv_data  (recv_data),
    .vald_data  (vald_data),
    .ready      (ready),
    .send       (send_a),
    .send_data  (sd_a),
    .fifo_count (cnt_a),
    .overflow   (ovf_a)
  );

  uart_echo_ctrl #(
    .DEPTH       (16),
    .CRLF_EXPAND (1'b0)
  ) dut_b (
    .CLK        (CLK),
    .RST        (RST),
    .recv_data  (recv_data),
    .vald_data  (vald_data),
    .ready      (ready),
    .send       (send_b),
    .send_data  (sd_b),
    .fifo_count (cnt_b),
    .overflow   (ovf_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // model state, index 0 = dut_a, 1 = dut_b
  logic [7:0] mq [2][$];
  bit         mlf  [2];
  bit         movf [2];
  bit         es   [2];
  logic [7:0] ed   [2];
  int         ec   [2];

  logic [7:0] log_a [$];
  logic [7:0] log_b [$];
  int         logc_a [$];

  bit tx_auto = 1'b0;
  int cd      = 0;
  int peak    = 0;
  bit track   = 1'b0;
  bit cmp_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic chk_seq(input string nm, input bit use_b, input int start, input logic [7:0] exp_q[$]);
    int n;
    n = use_b ? (log_b.size() - start) : (log_a.size() - start);
    chk({nm, "_len"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      chk(nm, use_b ? log_b[start + i] : log_a[start + i], exp_q[i]);
    end
  endtask

  // Model: sampled at each rising edge with the inputs the DUT sees.
  initial begin
    bit          go;
    logic [7:0]  b;
    int unsigned dep;
    bit          crx;
    for (int i = 0; i < 2; i++) begin
      mlf[i] = 0; movf[i] = 0; es[i] = 0; ed[i] = 8'h00; ec[i] = 0;
    end
    forever begin
      @(posedge CLK);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        dep = (i == 0) ? 4 : 16;
        crx = (i == 0);
        if (RST) begin
          mq[i].delete();
          mlf[i]  = 0;
          movf[i] = 0;
          es[i]   = 0;
          ed[i]   = 8'h00;
        end else begin
          go = !es[i] && ready && (mlf[i] || mq[i].size() != 0);
          if (go) begin
            if (mlf[i]) begin
              b      = 8'h0A;
              mlf[i] = 0;
            end else begin
              b      = mq[i].pop_front();
              mlf[i] = crx && (b == 8'h0D);
            end
            ed[i] = b;
          end
          if (vald_data) begin
            if (mq[i].size() < dep) mq[i].push_back(recv_data);
            else movf[i] = 1;
          end
          es[i] = go;
        end
        ec[i] = mq[i].size();
      end
    end
  end

  // Per-cycle compare, send logging and the auto-ready transmitter stand-in.
  initial begin
    forever begin
      @(negedge CLK);
      if (cmp_en) begin
        chk("a_send", send_a, es[0]);
        chk("a_data", sd_a, ed[0]);
        chk("a_count", cnt_a, ec[0]);
        chk("a_ovf", ovf_a, movf[0]);
        chk("b_send", send_b, es[1]);
        chk("b_data", sd_b, ed[1]);
        chk("b_count", cnt_b, ec[1]);
        chk("b_ovf", ovf_b, movf[1]);
      end
      if (send_a === 1'b1) begin
        log_a.push_back(sd_a);
        logc_a.push_back(cyc);
      end
      if (send_b === 1'b1) log_b.push_back(sd_b);
      if (track && int'(cnt_a) > peak) peak = cnt_a;
      if (tx_auto) begin
        if (send_a === 1'b1) cd = 10;
        else if (cd > 0) cd--;
        ready = (cd == 0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic push(input logic [7:0] b);
    recv_data = b;
    vald_data = 1'b1;
    tick(1);
    vald_data = 1'b0;
  endtask

  task automatic do_reset();
    RST       = 1'b1;
    vald_data = 1'b0;
    tick(1);
    RST       = 1'b0;
  endtask

  initial begin
    int         c0, ia, ib, ia2;
    logic [7:0] eq [$];

    RST = 1'b1; vald_data = 1'b0; ready = 1'b0; recv_data = 8'h00;
    tick(2);
    cmp_en = 1'b1;
    chk("rst_send_a", send_a, 0);
    chk("rst_data_a", sd_a, 8'h00);
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_ovf_a", ovf_a, 0);
    chk("rst_cnt_b", cnt_b, 0);
    RST = 1'b0;

    // single byte, latency two cycles
    ready = 1'b1;
    ia = log_a.size(); ib = log_b.size();
    c0 = cyc;
    push(8'h41);
    tick(6);
    eq = '{8'h41};
    chk_seq("t1_a", 0, ia, eq);
    chk_seq("t1_b", 1, ib, eq);
    if (logc_a.size() > ia) chk("t1_latency", logc_a[ia] - c0, 2);
    else chk("t1_latency_missing", log_a.size(), ia + 1);
    chk("t1_cnt", cnt_a, 0);

    // burst under a slow transmitter
    tx_auto = 1'b1;
    ia = log_a.size(); ib = log_b.size();
    peak = 0; track = 1'b1;
    push(8'h41); push(8'h52); push(8'h54);
    tick(60);
    track = 1'b0;
    chk("t2_peak", peak, 2);
    eq = '{8'h41, 8'h52, 8'h54};
    chk_seq("t2_a", 0, ia, eq);
    chk_seq("t2_b", 1, ib, eq);

    // CR expansion only on the CRLF instance
    ia = log_a.size(); ib = log_b.size();
    push(8'h0D); push(8'h58);
    tick(60);
    eq = '{8'h0D, 8'h0A, 8'h58};
    chk_seq("t3_a", 0, ia, eq);
    eq = '{8'h0D, 8'h58};
    chk_seq("t3_b", 1, ib, eq);
    tx_auto = 1'b0;

    // overflow on the depth-4 instance
    ready = 1'b0;
    do_reset();
    ia = log_a.size(); ib = log_b.size();
    for (int k = 1; k <= 4; k++) push(8'(k));
    chk("t4_cnt4", cnt_a, 4);
    chk("t4_ovf_pre", ovf_a, 0);
    push(8'h05);
    chk("t4_ovf_5", ovf_a, 1);
    chk("t4_cnt5", cnt_a, 4);
    push(8'h06);
    chk("t4_cnt6", cnt_a, 4);
    chk("t4_cnt_b", cnt_b, 6);
    ready = 1'b1;
    tick(30);
    eq = '{8'h01, 8'h02, 8'h03, 8'h04};
    chk_seq("t4_a", 0, ia, eq);
    eq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    chk_seq("t4_b", 1, ib, eq);
    chk("t4_ovf_sticky", ovf_a, 1);
    chk("t4_ovf_b", ovf_b, 0);

    // full FIFO with a simultaneous pop and push
    do_reset();
    ia = log_a.size(); ib = log_b.size();
    ready = 1'b1;
    push(8'h11);
    tick(1);
    ready = 1'b0;
    push(8'h22); push(8'h33); push(8'h44); push(8'h55);
    chk("t5_full", cnt_a, 4);
    recv_data = 8'hAA; vald_data = 1'b1; ready = 1'b1;
    tick(1);
    vald_data = 1'b0;
    chk("t5_cnt_hold", cnt_a, 4);
    chk("t5_ovf", ovf_a, 0);
    tick(30);
    eq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hAA};
    chk_seq("t5_a", 0, ia, eq);
    chk_seq("t5_b", 1, ib, eq);
    chk("t5_ovf_end", ovf_a, 0);

    // reset while waiting with queued bytes
    do_reset();
    ia = log_a.size();
    ready = 1'b1;
    push(8'h61);
    tick(1);
    ready = 1'b0;
    push(8'h62); push(8'h63); push(8'h64);
    chk("t6_queued", cnt_a, 3);
    RST = 1'b1; recv_data = 8'h65; vald_data = 1'b1; ready = 1'b1;
    tick(1);
    RST = 1'b0; vald_data = 1'b0;
    chk("t6_cnt", cnt_a, 0);
    chk("t6_send", send_a, 0);
    chk("t6_cnt_b", cnt_b, 0);
    ia2 = log_a.size();
    tick(20);
    chk("t6_quiet", log_a.size() - ia2, 0);
    push(8'h66);
    tick(10);
    eq = '{8'h61, 8'h66};
    chk_seq("t6_a", 0, ia, eq);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_echo_ctrl.md
Name: uart_echo_ctrl

Overview:
- Sits between UART_RX_CTRL and UART_TX_CTRL. It is the consumer of recv_data/vald_data and the producer of send/send_data for the transmitter.
- Each received byte goes into an internal FIFO. Bytes are then re-transmitted in order using the TX ready handshake, so the board echoes everything typed.
- Optionally expands CR into CR LF.
- Reports FIFO occupancy and a sticky overflow flag.

Parameters:
- DEPTH, 16: FIFO depth in bytes. Power of two, minimum 2.
- CRLF_EXPAND, 1: 1 = after echoing 8'h0D, also send 8'h0A. 0 = pure echo.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- recv_data  in  8  byte from UART_RX_CTRL.
- vald_data  in  1  one-cycle strobe; recv_data is valid in that cycle.
- ready  in  1  from UART_TX_CTRL; high = transmitter idle.
- send  out  1  one-cycle request to UART_TX_CTRL.
- send_data  out  8  byte to transmit. Held stable from send until the next send.
- fifo_count  out  $clog2(DEPTH)+1  number of stored bytes.
- overflow  out  1  sticky; set when a byte is dropped.

Behaviour:

Reset (RST=1 at posedge):
- state=IDLE; FIFO emptied; fifo_count=0.
- send=0, send_data=8'h00, overflow=0, lf_pending=0.
- Reset wins over any simultaneous vald_data or ready.
- Reset mid-transmission drops the in-flight byte and all queued bytes. No send is issued in the cycle after reset.

Push:
- vald_data=1 and FIFO not full: write recv_data at the tail; count+1 at the edge.
- vald_data=1 and FIFO full: byte discarded, overflow<=1.
- Exception: if a pop occurs in the same cycle, the write is accepted and count is unchanged.

States:
- IDLE:
  - FIFO non-empty and ready=1 → pop head into send_data, send<=1, go to GUARD.
  - lf_pending<=(CRLF_EXPAND and head==8'h0D).
- GUARD: send<=0. Unconditional → WAIT_RDY. This one cycle masks the TX ready deassertion latency.
- WAIT_RDY, when ready=1:
  - if lf_pending: send_data<=8'h0A, send<=1, lf_pending<=0, → GUARD.
  - else if FIFO non-empty: pop as in IDLE, → GUARD.
  - else → IDLE.
- Unused encodings → IDLE.

Timing and handshake rules:
- send is high for exactly one cycle per byte, never in two consecutive cycles.
- Latency: vald_data in cycle 0 with empty FIFO, state IDLE, ready=1 → send=1 in cycle 2 carrying that byte.
- Ordering is strictly FIFO. An expanded LF is sent before the next queued byte.

Count and pointers:
- fifo_count = writes − reads. Range 0..DEPTH.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- full = (count==DEPTH); empty = (count==0).
- Pop on empty never occurs; implementation asserts this in simulation.

Decomposition:
- Package uart_echo_pkg:
  - state encodings IDLE/GUARD/WAIT_RDY.
  - ASCII constants CHR_CR=8'h0D, CHR_LF=8'h0A.
  - count-width function.
- One sub-module: byte_fifo.
  - Synchronous, parameter DEPTH; ports CLK, RST, wr_en, wr_data, rd_en, rd_data (first-word fall-through), full, empty, count.
- uart_echo_ctrl holds the FSM, lf_pending and the overflow logic.

Test Plan:
1. Single byte: ready=1, vald_data pulse with 8'h41 at cycle 0 → send=1 with send_data=8'h41 at cycle 2 and only then; fifo_count returns to 0.
2. Burst: 8'h41, 8'h52, 8'h54 on three consecutive cycles; TX model holds ready low 10 cycles after each send → three sends in order 41,52,54; fifo_count peaks at 2.
3. CR expansion (CRLF_EXPAND=1): push 8'h0D then 8'h58 → sends 0D, 0A, 58. With CRLF_EXPAND=0 → 0D, 58 only.
4. Overflow: DEPTH=4, ready held 0, push 6 bytes 01..06 → fifo_count=4, overflow=1 after the 5th push; on release of ready, sends 01..04; overflow stays 1 until RST.
5. Full plus simultaneous pop: DEPTH=4 full, WAIT_RDY sees ready=1 in the same cycle as vald_data with 8'hAA → byte accepted, count stays 4, overflow stays 0, 8'hAA sent last.
6. Reset mid-operation: RST=1 for one cycle while in WAIT_RDY with 3 bytes queued → next cycle count=0, send=0, state IDLE; no further sends until a new vald_data.
